// File: rtl/uart_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_int_ctrl
// Purpose  : 16550-style interrupt controller for the UART datapath. Tracks
//            pending sources (line status, RX data trigger, character timeout,
//            THR empty, modem status), arbitrates them by fixed priority and
//            drives a registered IIR code and IRQ line. Owns the character
//            timeout counter, clocked by the 16x baud enable tick.
// Ports    : PCLK/PRESET     clock, asynchronous active-high reset
//            enable          16x baud tick (one PCLK wide)
//            LCR, IER        line control, interrupt enables
//            FCR_trig        RX trigger level select
//            rx_fifo_count   RX FIFO occupancy
//            push/pop_rx_fifo, line_err   RX FIFO traffic and error pulses
//            tx_fifo_empty, tx_push       TX FIFO level and THR write
//            lsr_read, iir_read, msr_read, ms_change   CPU/modem events
//            IIR, IRQ        interrupt identification and request
//            lsr_err         sticky {BI,FE,PE,OE}
//            char_timeout    timeout pending flag
// Options  : define UART_CTI_EN to build the character-timeout counter/FSM and
//            the CTI priority slot; without it char_timeout is tied low.
// Revision : 1.0  initial release
// ============================================================================
module uart_int_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int TO_CHARS   = 4
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          enable,
  input  logic [7:0]                    LCR,
  input  logic [3:0]                    IER,
  input  logic [1:0]                    FCR_trig,
  input  logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  input  logic                          push_rx_fifo,
  input  logic                          pop_rx_fifo,
  input  logic [3:0]                    line_err,
  input  logic                          tx_fifo_empty,
  input  logic                          tx_push,
  input  logic                          lsr_read,
  input  logic                          iir_read,
  input  logic                          msr_read,
  input  logic                          ms_change,
  output logic [3:0]                    IIR,
  output logic                          IRQ,
  output logic [3:0]                    lsr_err,
  output logic                          char_timeout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] trig_level;
  logic          rda_pend;
  logic          thre_pend;
  logic          ms_pend;
  logic          tx_empty_q;
  logic          thre_set;
  logic          thre_clr;
  logic [3:0]    next_iir;
  logic          cti_pend;

  always_comb begin
    trig_level = CW'(1);
    case (FCR_trig)
      2'b00:   trig_level = CW'(1);
      2'b01:   trig_level = CW'(4);
      2'b10:   trig_level = CW'(8);
      default: trig_level = CW'(14);
    endcase
  end

  assign rda_pend = (rx_fifo_count >= trig_level);

  // Line status: per-bit set has priority over the clearing LSR read.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      lsr_err <= 4'b0000;
    end else begin
      lsr_err <= (lsr_read ? 4'b0000 : lsr_err) | (push_rx_fifo ? line_err : 4'b0000);
    end
  end

  // THRE is raised only on the empty edge, so an already-empty FIFO does not
  // re-raise it after the CPU has acknowledged it.
  assign thre_set = tx_fifo_empty & ~tx_empty_q;
  assign thre_clr = tx_push | (iir_read & (IIR == 4'b0010));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_empty_q <= 1'b0;
      thre_pend  <= 1'b0;
      ms_pend    <= 1'b0;
    end else begin
      tx_empty_q <= tx_fifo_empty;
      thre_pend  <= thre_set | (thre_pend & ~thre_clr);
      ms_pend    <= ms_change | (ms_pend & ~msr_read);
    end
  end

`ifdef UART_CTI_EN
  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_COUNT = 2'd1,
    TO_FIRED = 2'd2
  } to_state_t;

  to_state_t  to_state;
  logic [9:0] to_cnt;
  logic [3:0] char_bits;
  logic [9:0] threshold;
  logic       unused_cti;

  // start + data(5..8) + parity + stop(1..2)
  assign char_bits = 4'd7 + {2'b00, LCR[1:0]} + {3'b000, LCR[3]} + {3'b000, LCR[2]};
  assign threshold = 10'({6'd0, char_bits} * 10'(16 * TO_CHARS));
  assign unused_cti = ^LCR[7:4];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_state     <= TO_IDLE;
      to_cnt       <= 10'd0;
      char_timeout <= 1'b0;
    end else begin
      case (to_state)
        TO_IDLE: begin
          to_cnt       <= 10'd0;
          char_timeout <= 1'b0;
          if (rx_fifo_count != '0) to_state <= TO_COUNT;
        end
        TO_COUNT: begin
          if (rx_fifo_count == '0) begin
            to_state <= TO_IDLE;
            to_cnt   <= 10'd0;
          end else if (push_rx_fifo | pop_rx_fifo) begin
            to_cnt <= 10'd0;
          end else if (enable) begin
            // >= rather than == so that an LCR change lowering the threshold
            // below the running count still fires on the next tick.
            if (to_cnt >= threshold - 10'd1) begin
              to_state     <= TO_FIRED;
              char_timeout <= 1'b1;
              to_cnt       <= 10'd0;
            end else begin
              to_cnt <= to_cnt + 10'd1;
            end
          end
        end
        TO_FIRED: begin
          if (push_rx_fifo | pop_rx_fifo) begin
            char_timeout <= 1'b0;
            to_cnt       <= 10'd0;
            // Popping the last character empties the FIFO on this edge.
            if (pop_rx_fifo & ~push_rx_fifo & (rx_fifo_count == CW'(1)))
              to_state <= TO_IDLE;
            else
              to_state <= TO_COUNT;
          end else if (rx_fifo_count == '0) begin
            char_timeout <= 1'b0;
            to_state     <= TO_IDLE;
          end
        end
        default: begin
          to_state     <= TO_IDLE;
          to_cnt       <= 10'd0;
          char_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign cti_pend = IER[0] & char_timeout;
`else
  logic unused_cti;

  assign char_timeout = 1'b0;
  assign cti_pend     = 1'b0;
  assign unused_cti   = ^{enable, LCR, pop_rx_fifo};
`endif

  always_comb begin
    next_iir = 4'b0001;
    if (IER[2] & (|lsr_err))    next_iir = 4'b0110;
    else if (IER[0] & rda_pend) next_iir = 4'b0100;
    else if (cti_pend)          next_iir = 4'b1100;
    else if (IER[1] & thre_pend) next_iir = 4'b0010;
    else if (IER[3] & ms_pend)  next_iir = 4'b0000;
  end

  // Held during an IIR read so the CPU sees a stable code.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      IIR <= 4'b0001;
    end else if (!iir_read) begin
      IIR <= next_iir;
    end
  end

  assign IRQ = ~IIR[0];

endmodule
`default_nettype wire

// File: tb/tb_uart_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_int_ctrl
// Purpose  : Self-checking bench for uart_int_ctrl. Expected {IIR,IRQ} values
//            are queued when stimulus is driven and popped when sampled.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_int_ctrl;

`ifdef UART_CTI_EN
  localparam logic [3:0] CTI_CODE = 4'b1100;
  localparam logic       CTI_ON   = 1'b1;
`else
  localparam logic [3:0] CTI_CODE = 4'b0001;
  localparam logic       CTI_ON   = 1'b0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       enable;
  logic [7:0] LCR;
  logic [3:0] IER;
  logic [1:0] FCR_trig;
  logic [4:0] rx_fifo_count;
  logic       push_rx_fifo;
  logic       pop_rx_fifo;
  logic [3:0] line_err;
  logic       tx_fifo_empty;
  logic       tx_push;
  logic       lsr_read;
  logic       iir_read;
  logic       msr_read;
  logic       ms_change;
  logic [3:0] IIR;
  logic       IRQ;
  logic [3:0] lsr_err;
  logic       char_timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;

  uart_int_ctrl #(.FIFO_DEPTH(16), .TO_CHARS(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .LCR(LCR), .IER(IER),
    .FCR_trig(FCR_trig), .rx_fifo_count(rx_fifo_count),
    .push_rx_fifo(push_rx_fifo), .pop_rx_fifo(pop_rx_fifo), .line_err(line_err),
    .tx_fifo_empty(tx_fifo_empty), .tx_push(tx_push), .lsr_read(lsr_read),
    .iir_read(iir_read), .msr_read(msr_read), .ms_change(ms_change),
    .IIR(IIR), .IRQ(IRQ), .lsr_err(lsr_err), .char_timeout(char_timeout)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task tick;
    @(posedge PCLK);
    #1;
  endtask

  task set_defaults;
    enable = 0; LCR = 8'h03; IER = 4'h0; FCR_trig = 2'b00; rx_fifo_count = 5'd0;
    push_rx_fifo = 0; pop_rx_fifo = 0; line_err = 4'h0; tx_fifo_empty = 0;
    tx_push = 0; lsr_read = 0; iir_read = 0; msr_read = 0; ms_change = 0;
  endtask

  task do_reset;
    PRESET = 1;
    set_defaults();
    tick(); tick();
    PRESET = 0;
    tick();
  endtask

  task test_reset;
    tick(); tick();
    exp_q.push_back({4'b0001, 1'b0}); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL reset_iir got %b want %b", {IIR, IRQ}, e); end
    PRESET = 0;
    tick();
    IER = 4'b0100;
    push_rx_fifo = 1; line_err = 4'b1000; tick(); push_rx_fifo = 0; line_err = 0; rx_fifo_count = 1;
    vectors++;
    if (lsr_err !== 4'b1000) begin miscompares++; $display("FAIL reset_pre_lsr got %b want %b", lsr_err, 4'b1000); end
    exp_q.push_back({4'b0110, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL reset_pre_iir got %b want %b", {IIR, IRQ}, e); end
    #2 PRESET = 1;
    #1;
    exp_q.push_back({4'b0001, 1'b0}); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL reset_async_iir got %b want %b", {IIR, IRQ}, e); end
    vectors++;
    if (lsr_err !== 4'b0000) begin miscompares++; $display("FAIL reset_async_lsr got %b want %b", lsr_err, 4'b0000); end
    vectors++;
    if (char_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_async_cti got %b want %b", char_timeout, 1'b0); end
  endtask

  task test_trigger;
    logic [4:0] lvl;
    do_reset();
    IER = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      lvl = (t == 0) ? 5'd1 : (t == 1) ? 5'd4 : (t == 2) ? 5'd8 : 5'd14;
      FCR_trig = 2'(t);
      rx_fifo_count = lvl - 5'd1;
      exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
      if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL trig_below t=%0d got %b want %b", t, {IIR, IRQ}, e); end
      rx_fifo_count = lvl;
      exp_q.push_back({4'b0100, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
      if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL trig_at t=%0d got %b want %b", t, {IIR, IRQ}, e); end
    end
    do_reset();
    IER = 4'b0001; FCR_trig = 2'b10;
    for (int i = 0; i < 8; i++) begin
      push_rx_fifo = 1; tick(); push_rx_fifo = 0; rx_fifo_count = rx_fifo_count + 5'd1;
    end
    exp_q.push_back({4'b0001, 1'b0}); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL trig_push8_same got %b want %b", {IIR, IRQ}, e); end
    exp_q.push_back({4'b0100, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL trig_push8_next got %b want %b", {IIR, IRQ}, e); end
    pop_rx_fifo = 1;
    exp_q.push_back({4'b0100, 1'b1}); tick(); pop_rx_fifo = 0; rx_fifo_count = 5'd7; e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL trig_pop_same got %b want %b", {IIR, IRQ}, e); end
    exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL trig_pop_next got %b want %b", {IIR, IRQ}, e); end
  endtask

  task test_timeout;
    do_reset();
    LCR = 8'h03; IER = 4'b0001; FCR_trig = 2'b11; enable = 1;
    push_rx_fifo = 1; tick(); push_rx_fifo = 0; rx_fifo_count = 5'd1;
    tick();
    repeat (639) tick();
    vectors++;
    if (char_timeout !== 1'b0) begin miscompares++; $display("FAIL to_early got %b want %b", char_timeout, 1'b0); end
    tick();
    vectors++;
    if (char_timeout !== CTI_ON) begin miscompares++; $display("FAIL to_fire got %b want %b", char_timeout, CTI_ON); end
    exp_q.push_back({CTI_CODE, CTI_ON}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL to_iir got %b want %b", {IIR, IRQ}, e); end
    pop_rx_fifo = 1;
    exp_q.push_back({CTI_CODE, CTI_ON}); tick(); pop_rx_fifo = 0; rx_fifo_count = 5'd0; e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL to_pop_iir got %b want %b", {IIR, IRQ}, e); end
    vectors++;
    if (char_timeout !== 1'b0) begin miscompares++; $display("FAIL to_pop_clr got %b want %b", char_timeout, 1'b0); end
    exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL to_after_pop got %b want %b", {IIR, IRQ}, e); end
    enable = 0;
  endtask

  task test_reset_mid_count;
    do_reset();
    LCR = 8'h03; IER = 4'b0001; FCR_trig = 2'b11; enable = 1; rx_fifo_count = 5'd3;
    tick();
    repeat (300) tick();
    #2 PRESET = 1;
    #1;
    exp_q.push_back({4'b0001, 1'b0}); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL midrst_iir got %b want %b", {IIR, IRQ}, e); end
    vectors++;
    if (char_timeout !== 1'b0) begin miscompares++; $display("FAIL midrst_cti got %b want %b", char_timeout, 1'b0); end
    tick();
    PRESET = 0;
    tick();
    repeat (639) tick();
    vectors++;
    if (char_timeout !== 1'b0) begin miscompares++; $display("FAIL midrst_early got %b want %b", char_timeout, 1'b0); end
    tick();
    vectors++;
    if (char_timeout !== CTI_ON) begin miscompares++; $display("FAIL midrst_fire got %b want %b", char_timeout, CTI_ON); end
    exp_q.push_back({CTI_CODE, CTI_ON}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL midrst_iir2 got %b want %b", {IIR, IRQ}, e); end
    enable = 0;
  endtask

  task test_priority;
    do_reset();
    IER = 4'b0101; FCR_trig = 2'b00;
    push_rx_fifo = 1; line_err = 4'b0010; tick(); push_rx_fifo = 0; line_err = 0; rx_fifo_count = 5'd1;
    vectors++;
    if (lsr_err !== 4'b0010) begin miscompares++; $display("FAIL prio_lsr got %b want %b", lsr_err, 4'b0010); end
    exp_q.push_back({4'b0110, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL prio_rls got %b want %b", {IIR, IRQ}, e); end
    lsr_read = 1;
    exp_q.push_back({4'b0110, 1'b1}); tick(); lsr_read = 0; e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL prio_lsrrd_same got %b want %b", {IIR, IRQ}, e); end
    exp_q.push_back({4'b0100, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL prio_rda got %b want %b", {IIR, IRQ}, e); end
    push_rx_fifo = 1; line_err = 4'b0001; lsr_read = 1;
    tick(); push_rx_fifo = 0; line_err = 0; lsr_read = 0; rx_fifo_count = 5'd2;
    vectors++;
    if (lsr_err !== 4'b0001) begin miscompares++; $display("FAIL prio_setwins got %b want %b", lsr_err, 4'b0001); end
    IER = 4'b0001;
    exp_q.push_back({4'b0100, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL prio_gated got %b want %b", {IIR, IRQ}, e); end
    IER = 4'b0101;
    exp_q.push_back({4'b0110, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL prio_regated got %b want %b", {IIR, IRQ}, e); end
  endtask

  task test_thre;
    do_reset();
    IER = 4'b0010;
    tx_fifo_empty = 1;
    exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL thre_edge got %b want %b", {IIR, IRQ}, e); end
    exp_q.push_back({4'b0010, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL thre_set got %b want %b", {IIR, IRQ}, e); end
    iir_read = 1;
    exp_q.push_back({4'b0010, 1'b1}); tick(); iir_read = 0; e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL thre_iirrd_same got %b want %b", {IIR, IRQ}, e); end
    exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL thre_iirrd_clr got %b want %b", {IIR, IRQ}, e); end
    tx_fifo_empty = 0; tick();
    tx_fifo_empty = 1; tx_push = 1; tick(); tx_push = 0;
    exp_q.push_back({4'b0010, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL thre_setwins got %b want %b", {IIR, IRQ}, e); end
    tx_push = 1; tick(); tx_push = 0;
    exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL thre_push_clr got %b want %b", {IIR, IRQ}, e); end
  endtask

  task test_modem;
    do_reset();
    IER = 4'b1000;
    ms_change = 1; tick(); ms_change = 0;
    iir_read = 1;
    exp_q.push_back({4'b0001, 1'b0}); tick(); iir_read = 0; e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL ms_frozen got %b want %b", {IIR, IRQ}, e); end
    exp_q.push_back({4'b0000, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL ms_set got %b want %b", {IIR, IRQ}, e); end
    msr_read = 1; ms_change = 1; tick(); msr_read = 0; ms_change = 0;
    exp_q.push_back({4'b0000, 1'b1}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL ms_setwins got %b want %b", {IIR, IRQ}, e); end
    msr_read = 1; tick(); msr_read = 0;
    exp_q.push_back({4'b0001, 1'b0}); tick(); e = exp_q.pop_front(); vectors++;
    if ({IIR, IRQ} !== e) begin miscompares++; $display("FAIL ms_clr got %b want %b", {IIR, IRQ}, e); end
  endtask

  initial begin
    PRESET = 1;
    set_defaults();
    test_reset();
    test_trigger();
    test_timeout();
`ifdef UART_CTI_EN
    test_reset_mid_count();
`endif
    test_priority();
    test_thre();
    test_modem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_int_ctrl.md
Name: uart_int_ctrl

Overview:
Interrupt controller and scheduler for the UART receive/transmit datapath. It tracks pending sources: line status errors, RX data trigger level, character timeout, THR empty and modem status. It arbitrates them by fixed 16550 priority and drives a registered IIR code and IRQ line to the APB register block. It owns the character-timeout counter, clocked by the 16x baud enable tick.

Parameters:
- FIFO_DEPTH, 16, RX FIFO depth; count port width is clog2(FIFO_DEPTH)+1.
- TO_CHARS, 4, character times of RX inactivity before a timeout is raised.

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  asynchronous, active-high reset.
- enable  in  1  16x baud tick, one PCLK wide.
- LCR  in  8  line control; [1:0] word length, [2] stop bits, [3] parity enable.
- IER  in  4  [0] RDA/CTI, [1] THRE, [2] RLS, [3] MS enables.
- FCR_trig  in  2  RX trigger level select.
- rx_fifo_count  in  5  RX FIFO occupancy.
- push_rx_fifo  in  1  RX engine writes a character.
- pop_rx_fifo  in  1  CPU reads RBR.
- line_err  in  4  {break, framing, parity, overrun} pulse from RX engine, sampled on push_rx_fifo.
- tx_fifo_empty  in  1  TX FIFO empty level.
- tx_push  in  1  CPU writes THR.
- lsr_read  in  1  CPU reads LSR (pulse).
- iir_read  in  1  CPU reads IIR (pulse).
- msr_read  in  1  CPU reads MSR (pulse).
- ms_change  in  1  any delta modem status bit set (pulse).
- IIR  out  4  interrupt identification code.
- IRQ  out  1  interrupt request, active high.
- lsr_err  out  4  sticky {BI,FE,PE,OE} for LSR.
- char_timeout  out  1  timeout pending flag.

Behaviour:
- Reset: IIR=4'b0001, IRQ=0, lsr_err=0, char_timeout=0, all pending flags 0, timeout counter 0, FSM TO_IDLE.
- Trigger level from FCR_trig: 00→1, 01→4, 10→8, 11→14.
  - rda_pend = (rx_fifo_count >= level), combinational from the count.
- rls_pend / lsr_err:
  - Each bit is set on push_rx_fifo when the matching line_err bit is 1.
  - All bits clear on lsr_read.
  - Set and lsr_read in the same cycle: set wins.
- thre_pend:
  - Set on the rising edge of tx_fifo_empty (edge detected by an internal register).
  - Cleared by tx_push, or by iir_read while IIR==4'b0010.
  - Set and clear in the same cycle: set wins.
- ms_pend: set on ms_change; cleared on msr_read; set wins on collision.
- Character time in ticks: bits = 1 + (5+LCR[1:0]) + LCR[3] + 1 + LCR[2]. Threshold T = bits*16*TO_CHARS, a 10-bit unsigned value; max 12*64=768.
- Timeout FSM:
  - TO_IDLE: counter=0. Go to TO_COUNT when rx_fifo_count!=0.
  - TO_COUNT:
    - Counter increments on enable.
    - push_rx_fifo or pop_rx_fifo resets the counter to 0 and stays in TO_COUNT.
    - rx_fifo_count==0 returns to TO_IDLE.
    - On enable with counter==T-1, go to TO_FIRED and set char_timeout=1.
  - TO_FIRED: char_timeout held at 1. pop_rx_fifo or push_rx_fifo clears char_timeout, zeroes the counter and returns to TO_COUNT, or to TO_IDLE if the FIFO will become empty.
  - An LCR change mid-count takes effect on the next compare; the counter is not reset.
- Priority, highest first. Gated by IER; a disabled source never appears but stays pending.
  - RLS, IER[2] & |lsr_err → 4'b0110.
  - RDA, IER[0] & rda_pend → 4'b0100.
  - CTI, IER[0] & char_timeout → 4'b1100.
  - THRE, IER[1] & thre_pend → 4'b0010.
  - MS, IER[3] & ms_pend → 4'b0000.
  - None → 4'b0001.
- IIR and IRQ are registered: one PCLK latency from a pending-flag change to the outputs. IRQ = ~IIR[0] of the registered value.
- IIR is frozen during a cycle with iir_read=1, so the CPU sees a stable code; it updates on the following cycle.
- FIFO full (count==FIFO_DEPTH) needs no special action; overrun arrives via line_err.

Optional Feature:
- Macro UART_CTI_EN.
- Defined: timeout counter, FSM and CTI priority slot are present as specified.
- Undefined: no counter or FSM logic; char_timeout tied 0; IIR never 4'b1100; all other priorities unchanged.

Test Plan:
- Reset mid-count: assert PRESET with the FIFO at 3 and the counter at 300 → asynchronously IIR=0001, IRQ=0, char_timeout=0; after release the count restarts from 0.
- Trigger level: FCR_trig=10, IER=0001, push 8 chars → IIR=0100 and IRQ=1 one cycle after count reaches 8; pop one → IIR=0001 one cycle later.
- Timeout: LCR=0x03 (T=640), enable every cycle, push 1 char, IER=0001 → char_timeout=1 after exactly 640 ticks, IIR=1100; pop → cleared, IIR=0001. Undefined UART_CTI_EN → IIR stays 0001.
- Priority: parity error and count≥trigger together with IER=0101 → IIR=0110; lsr_read → IIR=0100 next cycle.
- THRE: IER=0010, tx_fifo_empty 0→1 → IIR=0010; iir_read → IIR=0001; tx_fifo_empty rise coincident with tx_push → thre_pend stays set.
- Modem status: ms_change with IER=1000 → IIR=0000, IRQ=1; msr_read coincident with a new ms_change → remains pending.
